logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter SW, default $clog2(N), the shift-amount width, derived from N and not overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream operation valid.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port op  input  3  operation select: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 SLL, 7 SRL.
REQ-008 SHALL have port a  input  N  operand A.
REQ-009 SHALL have port b  input  N  operand B; shift amount is b[SW-1:0].
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port result  output  N  operation result.
REQ-013 SHALL have port flags  output  4  {N,Z,C,V}, aligned with result.

Function
REQ-014 SHALL implement a 2-stage pipeline: S1 registers op/a/b, S2 registers result/flags; each stage has its own valid bit.
REQ-015 SHALL accept an operation when in_valid && in_ready are both high at a rising edge (transfer).
REQ-016 SHALL deliver a result when out_valid && out_ready are both high at a rising edge.
REQ-017 SHALL assert in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready (combinational, no dependence on in_valid).
REQ-018 SHALL present result exactly 2 cycles after acceptance with no backpressure; sustained throughput is 1 operation per cycle.
REQ-019 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL lose, duplicate or reorder no operation under any in_valid/out_ready pattern.
REQ-021 SHALL accept a new operation into S1 in the same cycle S1 advances to S2 (simultaneous accept and advance).
REQ-022 SHALL compute NOT as the full-width bitwise inverse ~a; b is ignored; no shift is applied.
REQ-023 SHALL compute AND, OR, XOR, NAND and NOR bitwise across all N bits.
REQ-024 SHALL compute SLL as a << b[SW-1:0] and SRL as a >> b[SW-1:0] (logical, zero fill); bits of b above SW-1 are ignored.
REQ-025 SHALL set flag N = result[N-1] and Z = (result == 0), and V = 0 for every operation.
REQ-026 SHALL set C for SLL to a[N-sh] and for SRL to a[sh-1] (the last bit shifted out), where sh = b[SW-1:0]; C = 0 when sh = 0 and for all non-shift ops.
REQ-027 SHALL register outputs only: result, flags and out_valid are driven directly from S2 flops.

Reset
REQ-028 SHALL, while rst is high at a rising edge, clear s1_valid and s2_valid to 0; result and flags reset to 0.
REQ-029 SHALL keep in_ready at 0 while rst is high and drive it per REQ-017 from the first cycle after rst deasserts.
REQ-030 SHALL discard all in-flight operations when rst asserts mid-operation; none appears on the output afterwards.
REQ-031 SHALL ignore in_valid during any cycle in which rst is high.

Verification
REQ-032 SHALL be checked: N=32, op=0, a=0x0000_00F0, out_ready=1 -> 2 cycles later result=0xFFFF_FF0F, flags=N1 Z0 C0 V0.
REQ-033 SHALL be checked: op=6, a=0x8000_0001, b=0x0000_0021 (sh=1) -> result=0x0000_0002, C=1, Z=0, N=0; op=7, a=0x1, b=1 -> result=0, Z=1, C=1.
REQ-034 SHALL be checked: op=3, a=b=0xDEAD_BEEF -> result=0, Z=1; op=5, a=b=0 -> result=0xFFFF_FFFF, N=1.
REQ-035 SHALL be checked: back-to-back stream of 16 ops with out_ready=1 -> 16 results on 16 consecutive cycles starting 2 cycles after first acceptance, in order.
REQ-036 SHALL be checked: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 ops accepted, in_ready=0 thereafter, result held stable; out_ready=1 -> both drain in order, no loss.
REQ-037 SHALL be checked: rst pulsed for 1 cycle with both stages valid -> next cycle out_valid=0, result=0, flags=0; no stale result emerges later.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready logic and shift unit
// S1 holds the accepted operands; S2 holds the registered result and {N,Z,C,V} flags.
module logic_unit_pipe #(
   parameter int N  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [3:0]   flags
);

   localparam logic [2:0] OP_NOT  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_SLL  = 3'd6;
   localparam logic [2:0] OP_SRL  = 3'd7;

   logic         s1_valid;
   logic [2:0]   s1_op;
   logic [N-1:0] s1_a;
   logic [N-1:0] s1_b;
   logic         s2_valid;
   logic         s1_adv;

   logic [N:0]   sll_ext;
   logic [N:0]   srl_ext;
   logic [N-1:0] calc_res;
   logic         calc_c;
   logic [3:0]   calc_flags;

   assign s1_adv    = !s2_valid || out_ready;
   assign in_ready  = !rst && (!s1_valid || s1_adv);
   assign out_valid = s2_valid;

   // One guard bit on each side of the shifted operand catches the last bit shifted out.
   always_comb begin
      sll_ext  = {1'b0, s1_a} << s1_b[SW-1:0];
      srl_ext  = {s1_a, 1'b0} >> s1_b[SW-1:0];
      calc_res = '0;
      calc_c   = 1'b0;
      case (s1_op)
         OP_NOT:  calc_res = ~s1_a;
         OP_AND:  calc_res = s1_a & s1_b;
         OP_OR:   calc_res = s1_a | s1_b;
         OP_XOR:  calc_res = s1_a ^ s1_b;
         OP_NAND: calc_res = ~(s1_a & s1_b);
         OP_NOR:  calc_res = ~(s1_a | s1_b);
         OP_SLL: begin
            calc_res = sll_ext[N-1:0];
            calc_c   = sll_ext[N];
         end
         OP_SRL: begin
            calc_res = srl_ext[N:1];
            calc_c   = srl_ext[0];
         end
         default: calc_res = '0;
      endcase
      calc_flags = {calc_res[N-1], (calc_res == '0), calc_c, 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         result   <= '0;
         flags    <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               result <= calc_res;
               flags  <= calc_flags;
            end
         end
      end
   end

   // Operand registers need no reset: s1_valid qualifies them.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_op <= op;
         s1_a  <= a;
         s1_b  <= b;
      end
   end

endmodule
